// File: rtl/wsum_pkg.sv
// Shared constants and helpers for the valid-sample window summer.
package wsum_pkg;

   localparam int W_DEF   = 4;
   localparam int N_DEF   = 4;
   localparam int IGN_DEF = 0;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++)
         if ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/wsum_line.sv
// N-entry delay line of valid samples; dout_oldest is the entry a push evicts.
module wsum_line
   import wsum_pkg::*;
#(
   parameter int W = W_DEF,
   parameter int N = N_DEF
) (
   input  logic         clk,
   input  logic         rst_b,
   input  logic         clr,
   input  logic         push,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout_oldest
);

   logic [W-1:0] line [N];

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         for (int i = 0; i < N; i++) line[i] <= '0;
      end else if (clr) begin
         for (int i = 0; i < N; i++) line[i] <= '0;
      end else if (push) begin
         line[0] <= din;
         for (int i = 1; i < N; i++) line[i] <= line[i-1];
      end
   end

   assign dout_oldest = line[N-1];

endmodule

// File: rtl/window_sum_ignore.sv
// Running sum of the last N samples that differ from IGN.
// Optional avg output (q >> clog2(N)) enabled by defining WSUM_AVG_EN.
module window_sum_ignore
   import wsum_pkg::*;
#(
   parameter int           W   = W_DEF,
   parameter int           N   = N_DEF,
   parameter logic [W-1:0] IGN = W'(IGN_DEF),
   localparam int          QW  = W + clog2(N),
   localparam int          CW  = clog2(N + 1)
) (
   input  logic          clk,
   input  logic          rst_b,
   input  logic          clr,
   input  logic [W-1:0]  d,
   output logic [QW-1:0] q,
   output logic [CW-1:0] cnt,
   output logic          full
`ifdef WSUM_AVG_EN
   ,
   output logic [W-1:0]  avg
`endif
);

   logic          push;
   logic [W-1:0]  oldest;
   logic [QW-1:0] evict;
   logic [QW-1:0] q_nxt;

   assign push = (d != IGN) && !clr;
   assign full = (cnt == CW'(N));

   wsum_line #(.W(W), .N(N)) u_line (
      .clk         (clk),
      .rst_b       (rst_b),
      .clr         (clr),
      .push        (push),
      .din         (d),
      .dout_oldest (oldest)
   );

   // Only a full window actually evicts; otherwise nothing leaves the sum.
   assign evict = full ? QW'(oldest) : '0;
   assign q_nxt = q + QW'(d) - evict;

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         q   <= '0;
         cnt <= '0;
      end else if (clr) begin
         q   <= '0;
         cnt <= '0;
      end else if (push) begin
         q <= q_nxt;
         if (!full) cnt <= cnt + CW'(1);
      end
   end

`ifdef WSUM_AVG_EN
   if ((N & (N - 1)) != 0) begin : g_bad_n
      $error("window_sum_ignore: N must be a power of two with avg");
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         avg <= '0;
      end else if (clr) begin
         avg <= '0;
      end else if (push) begin
         avg <= W'(q_nxt >> clog2(N));
      end
   end
`endif

endmodule

// File: tb/tb_window_sum_ignore.sv
// Directed bench: three instances (N=4/IGN=0, N=4/IGN=14, N=1/IGN=0)
// checked every cycle against a queue-based window model.
module tb_window_sum_ignore;

   logic       clk = 1'b0;
   logic       rst_b;
   logic       clr;
   logic [3:0] d;

   logic [5:0] q0, q1;
   logic [2:0] cnt0, cnt1;
   logic       full0, full1;
   logic [3:0] qn;
   logic [0:0] cntn;
   logic       fulln;
`ifdef WSUM_AVG_EN
   logic [3:0] avg0, avg1, avgn;
`endif

   int compared   = 0;
   int mismatched = 0;
   bit chk_en     = 0;

   always #5 clk = ~clk;

   window_sum_ignore #(.W(4), .N(4), .IGN(4'd0)) u_dut (
      .clk(clk), .rst_b(rst_b), .clr(clr), .d(d),
      .q(q0), .cnt(cnt0), .full(full0)
`ifdef WSUM_AVG_EN
      , .avg(avg0)
`endif
   );

   window_sum_ignore #(.W(4), .N(4), .IGN(4'd14)) u_ign (
      .clk(clk), .rst_b(rst_b), .clr(clr), .d(d),
      .q(q1), .cnt(cnt1), .full(full1)
`ifdef WSUM_AVG_EN
      , .avg(avg1)
`endif
   );

   window_sum_ignore #(.W(4), .N(1), .IGN(4'd0)) u_n1 (
      .clk(clk), .rst_b(rst_b), .clr(clr), .d(d),
      .q(qn), .cnt(cntn), .full(fulln)
`ifdef WSUM_AVG_EN
      , .avg(avgn)
`endif
   );

   // Model: each window is just the queue of the last N valid samples.
   int win [3][$];
   int nwin [3] = '{4, 4, 1};
   int ign  [3] = '{0, 14, 0};
   int shft [3] = '{2, 2, 0};

   always @(posedge clk or negedge rst_b) begin
      for (int i = 0; i < 3; i++) begin
         if (!rst_b || clr) win[i].delete();
         else if (int'(d) != ign[i]) begin
            win[i].push_back(int'(d));
            if (win[i].size() > nwin[i]) void'(win[i].pop_front());
         end
      end
   end

   function automatic int wsum(input int i);
      int s = 0;
      foreach (win[i][k]) s += win[i][k];
      return s;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("m0_q",    int'(q0),    wsum(0));
         check("m0_cnt",  int'(cnt0),  win[0].size());
         check("m0_full", int'(full0), int'(win[0].size() == 4));
         check("m1_q",    int'(q1),    wsum(1));
         check("m1_cnt",  int'(cnt1),  win[1].size());
         check("m1_full", int'(full1), int'(win[1].size() == 4));
         check("mn_q",    int'(qn),    wsum(2));
         check("mn_cnt",  int'(cntn),  win[2].size());
         check("mn_full", int'(fulln), int'(win[2].size() == 1));
`ifdef WSUM_AVG_EN
         check("m0_avg",  int'(avg0),  wsum(0) >> shft[0]);
         check("m1_avg",  int'(avg1),  wsum(1) >> shft[1]);
         check("mn_avg",  int'(avgn),  wsum(2) >> shft[2]);
`endif
      end
   end

   task automatic step(input logic [3:0] dv, input logic cv);
      d   = dv;
      clr = cv;
      @(posedge clk);
      #1;
   endtask

   logic [3:0] sa [6] = '{4'd3, 4'd0, 4'd5, 4'd7, 4'd2, 4'd9};
   int ea_q [6]  = '{3, 3, 8, 15, 17, 23};
   int ea_c [6]  = '{1, 1, 2, 3, 4, 4};
   int ea_f [6]  = '{0, 0, 0, 0, 1, 1};
   int ea_a [6]  = '{0, 0, 2, 3, 4, 5};
   int eb_q [6]  = '{15, 30, 45, 60, 60, 60};
   int eb_c [6]  = '{1, 2, 3, 4, 4, 4};
   logic [3:0] sc [4] = '{4'd7, 4'd14, 4'd0, 4'd3};
   int ec_q [4]  = '{7, 7, 7, 10};
   int ec_c [4]  = '{1, 1, 2, 3};

   initial begin
      rst_b = 1'b0;
      clr   = 1'b0;
      d     = 4'd0;
      repeat (2) @(posedge clk);
      #1;
      rst_b  = 1'b1;
      chk_en = 1'b1;
      #1;
      check("rst_q", int'(q0), 0);
      check("rst_cnt", int'(cnt0), 0);
      check("rst_full", int'(full0), 0);

      for (int i = 0; i < 6; i++) begin
         step(sa[i], 1'b0);
         check($sformatf("a_q%0d", i), int'(q0), ea_q[i]);
         check($sformatf("a_cnt%0d", i), int'(cnt0), ea_c[i]);
         check($sformatf("a_full%0d", i), int'(full0), ea_f[i]);
`ifdef WSUM_AVG_EN
         check($sformatf("a_avg%0d", i), int'(avg0), ea_a[i]);
`endif
      end
      check("n1_last", int'(qn), 9);

      step(4'd6, 1'b1);
      check("clr_q", int'(q0), 0);
      check("clr_cnt", int'(cnt0), 0);
      step(4'd6, 1'b0);
      check("post_clr_q", int'(q0), 6);

      step(4'd0, 1'b1);
      for (int i = 0; i < 6; i++) begin
         step(4'd15, 1'b0);
         check($sformatf("b_q%0d", i), int'(q0), eb_q[i]);
         check($sformatf("b_cnt%0d", i), int'(cnt0), eb_c[i]);
      end

      step(4'd0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         step(sc[i], 1'b0);
         check($sformatf("c_q%0d", i), int'(q1), ec_q[i]);
         check($sformatf("c_cnt%0d", i), int'(cnt1), ec_c[i]);
      end
      check("n1_cnt", int'(cntn), 1);

      rst_b = 1'b0;
      #1;
      check("arst_q", int'(q1), 0);
      check("arst_cnt", int'(cnt1), 0);
      check("arst_q0", int'(q0), 0);
      d = 4'd5;
      repeat (3) @(posedge clk);
      #1;
      check("hold_q", int'(q0), 0);
      check("hold_cnt", int'(cnt0), 0);
      rst_b = 1'b1;
      step(4'd4, 1'b0);
      check("first_q", int'(q0), 4);
      check("first_cnt", int'(cnt0), 1);

      repeat (2) @(posedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/window_sum_ignore.md
WINDOW_SUM_IGNORE -- requirements
Module: window_sum_ignore

Interface
REQ-001 The block SHALL have parameter W, default 4, meaning data input width in bits (W >= 1).
REQ-002 The block SHALL have parameter N, default 4, meaning window depth in valid samples (N >= 1).
REQ-003 The block SHALL have parameter IGN, default 0 (W bits), meaning the input value treated as invalid and ignored.
REQ-004 The block SHALL derive local constants QW = W + clog2(N) and CW = clog2(N+1).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst_b, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have port clr, input, 1 bit: synchronous clear of the window.
REQ-008 The block SHALL have port d, input, W bits: sample input.
REQ-009 The block SHALL have port q, output reg, QW bits: sum of the last min(cnt, N) valid samples.
REQ-010 The block SHALL have port cnt, output reg, CW bits: number of valid samples held (0..N).
REQ-011 The block SHALL have port full, output, 1 bit: high iff cnt == N.

Function
REQ-012 A sample is valid on a rising edge iff d != IGN at that edge; otherwise it SHALL leave all state unchanged.
REQ-013 On a valid sample the block SHALL push d into an N-entry delay line of valid samples, discarding the oldest entry when full.
REQ-014 The running-sum update SHALL be q <= q + d - oldest, where oldest is the evicted entry when full and 0 otherwise; latency is one edge, with no combinational path from d to q.
REQ-015 On a valid sample cnt SHALL increment while cnt < N and saturate at N.
REQ-016 All arithmetic SHALL be unsigned at width QW; q SHALL never overflow (N * (2^W - 1) fits in QW bits).
REQ-017 When clr = 1 on an edge, q, cnt and every delay-line entry SHALL become 0; clr SHALL take priority over a simultaneous valid sample, which is discarded.
REQ-018 The value 0 SHALL be a valid sample whenever IGN != 0; it SHALL increment cnt and occupy a window slot.
REQ-019 With N = 1, q SHALL equal the last valid sample and cnt SHALL be 0 or 1.

Reset
REQ-020 When rst_b = 0, q, cnt and all delay-line entries SHALL clear to 0 immediately, without waiting for a clock edge; full SHALL be 0.
REQ-021 After rst_b rises, the first valid sample SHALL produce q = d and cnt = 1.

Configuration
REQ-022 Macro WSUM_AVG_EN: when it is defined, the block SHALL add output avg (W bits) equal to q >> clog2(N), registered with q; elaboration SHALL fail if N is not a power of two.
REQ-023 When WSUM_AVG_EN is not defined, the avg port and its logic SHALL be absent.

Structure
REQ-024 Package wsum_pkg SHALL hold the clog2 function and the default constants for W, N and IGN.
REQ-025 The delay line SHALL be sub-module wsum_line (params W, N; ports clk, rst_b, clr, push, din, dout_oldest); the adder and counter SHALL stay in the top module.

Verification
REQ-026 W=4, N=4, IGN=0: after reset, d = 3,0,5,7,2,9 on successive edges -> q = 3,3,8,15,17,23; cnt = 1,1,2,3,4,4; full rises on the 2.
REQ-027 W=4, N=4: d = 15 for 6 edges -> q = 15,30,45,60,60,60 and cnt saturates at 4.
REQ-028 IGN=14: d = 7,14,0,3 -> q = 7,7,7,10; cnt = 1,1,2,3.
REQ-029 Mid-stream with q = 23, assert clr together with d = 6 -> q = 0 and cnt = 0 after the edge; the next d = 6 gives q = 6.
REQ-030 rst_b driven low between edges with q != 0 -> q = 0 and cnt = 0 before the next clk edge; held low across edges, state stays 0.
REQ-031 With WSUM_AVG_EN defined, repeat the REQ-026 stimulus -> avg = 0,0,2,3,4,5.
